// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct fields,
// ALU operation codes, FSM state encoding and the bundled control word.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;
   localparam logic [5:0] FUNCT_MUL = 6'h18;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd4;
   localparam logic [2:0] ALU_MUL = 3'd5;
   localparam logic [2:0] ALU_SLT = 3'd6;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       i_or_d;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_sel;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct -> ALU operation mapping used by R-type execution.
// Unrecognised funct codes fall back to ADD.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_sel
);

   always_comb begin
      alu_sel = ALU_ADD;
      case (funct)
         FUNCT_ADD: alu_sel = ALU_ADD;
         FUNCT_SUB: alu_sel = ALU_SUB;
         FUNCT_AND: alu_sel = ALU_AND;
         FUNCT_OR:  alu_sel = ALU_OR;
         FUNCT_SLT: alu_sel = ALU_SLT;
         FUNCT_MUL: alu_sel = ALU_MUL;
         default:   alu_sel = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle MIPS datapath. The state register is
// the only storage; outputs decode from state, and pc_en also folds in zero.
module multicycle_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_en,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       i_or_d,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_sel,
   output logic [3:0] state
);

   logic [3:0] r_state;
   logic [3:0] w_next_state;
   logic [2:0] w_funct_alu_sel;
   ctrl_t      w_ctrl;

   alu_decoder u_alu_decoder (
      .funct   (funct),
      .alu_sel (w_funct_alu_sel)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next_state;
   end

   // opcode only steers the FSM from DECODE and MEMADR
   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_FETCH: w_next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_RTYPE:     w_next_state = S_EXECUTE;
               OP_BEQ:       w_next_state = S_BRANCH;
               OP_ADDI:      w_next_state = S_ADDIEXEC;
               OP_J:         w_next_state = S_JUMP;
               default:      w_next_state = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:    w_next_state = S_MEMWB;
         S_EXECUTE:  w_next_state = S_ALUWB;
         S_ADDIEXEC: w_next_state = S_ADDIWB;
         default:    w_next_state = S_FETCH;
      endcase
   end

   always_comb begin
      w_ctrl = CTRL_NONE;
      case (r_state)
         S_FETCH: begin
            w_ctrl.ir_write  = 1'b1;
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.alu_src_b = 2'b01;
            w_ctrl.alu_sel   = ALU_ADD;
            w_ctrl.pc_src    = 2'b00;
         end
         S_DECODE: begin
            w_ctrl.alu_src_b = 2'b11;
            w_ctrl.alu_sel   = ALU_ADD;
         end
         S_MEMADR, S_ADDIEXEC: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = 2'b10;
            w_ctrl.alu_sel   = ALU_ADD;
         end
         S_MEMRD: w_ctrl.i_or_d = 1'b1;
         S_MEMWB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            w_ctrl.i_or_d    = 1'b1;
            w_ctrl.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = 2'b00;
            w_ctrl.alu_sel   = w_funct_alu_sel;
         end
         S_ALUWB: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.reg_dst   = 1'b1;
         end
         S_ADDIWB: w_ctrl.reg_write = 1'b1;
         S_BRANCH: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = 2'b00;
            w_ctrl.alu_sel   = ALU_SUB;
            w_ctrl.branch    = 1'b1;
            w_ctrl.pc_src    = 2'b01;
         end
         S_JUMP: begin
            w_ctrl.pc_write = 1'b1;
            w_ctrl.pc_src   = 2'b10;
         end
         default: w_ctrl = CTRL_NONE;
      endcase
   end

   // Reset gates every output combinationally so nothing strobes before FETCH
   assign pc_en      = rst_n & (w_ctrl.pc_write | (w_ctrl.branch & zero));
   assign ir_write   = rst_n & w_ctrl.ir_write;
   assign mem_write  = rst_n & w_ctrl.mem_write;
   assign reg_write  = rst_n & w_ctrl.reg_write;
   assign i_or_d     = rst_n & w_ctrl.i_or_d;
   assign mem_to_reg = rst_n & w_ctrl.mem_to_reg;
   assign reg_dst    = rst_n & w_ctrl.reg_dst;
   assign alu_src_a  = rst_n & w_ctrl.alu_src_a;
   assign alu_src_b  = rst_n ? w_ctrl.alu_src_b : 2'b00;
   assign pc_src     = rst_n ? w_ctrl.pc_src    : 2'b00;
   assign alu_sel    = rst_n ? w_ctrl.alu_sel   : 3'b000;
   assign state      = rst_n ? r_state          : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through the
// FSM and compares state plus the packed control word every cycle.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en, ir_write, mem_write, reg_write, i_or_d, mem_to_reg, reg_dst, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_sel;
   logic [3:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   multicycle_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .pc_en      (pc_en),
      .ir_write   (ir_write),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .i_or_d     (i_or_d),
      .mem_to_reg (mem_to_reg),
      .reg_dst    (reg_dst),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .alu_sel    (alu_sel),
      .state      (state)
   );

   always #5 clk = ~clk;

   // {pc_en, ir_write, mem_write, reg_write, i_or_d, mem_to_reg, reg_dst, alu_src_a,
   //  alu_src_b[1:0], pc_src[1:0], alu_sel[2:0]}
   logic [14:0] w_obs;
   assign w_obs = {pc_en, ir_write, mem_write, reg_write, i_or_d, mem_to_reg, reg_dst,
                   alu_src_a, alu_src_b, pc_src, alu_sel};

   localparam logic [14:0] C_FETCH  = 15'b1_1_0_0_0_0_0_0_01_00_010;
   localparam logic [14:0] C_DECODE = 15'b0_0_0_0_0_0_0_0_11_00_010;
   localparam logic [14:0] C_ADR    = 15'b0_0_0_0_0_0_0_1_10_00_010;
   localparam logic [14:0] C_MEMRD  = 15'b0_0_0_0_1_0_0_0_00_00_000;
   localparam logic [14:0] C_MEMWB  = 15'b0_0_0_1_0_1_0_0_00_00_000;
   localparam logic [14:0] C_MEMWR  = 15'b0_0_1_0_1_0_0_0_00_00_000;
   localparam logic [14:0] C_EXEC   = 15'b0_0_0_0_0_0_0_1_00_00_000; // OR in alu_sel
   localparam logic [14:0] C_ALUWB  = 15'b0_0_0_1_0_0_1_0_00_00_000;
   localparam logic [14:0] C_ADDIWB = 15'b0_0_0_1_0_0_0_0_00_00_000;
   localparam logic [14:0] C_BR_Z1  = 15'b1_0_0_0_0_0_0_1_00_01_100;
   localparam logic [14:0] C_BR_Z0  = 15'b0_0_0_0_0_0_0_1_00_01_100;
   localparam logic [14:0] C_JUMP   = 15'b1_0_0_0_0_0_0_0_00_10_000;
   localparam logic [14:0] C_ZERO   = 15'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Inputs are already set; check the current cycle, then advance one clock.
   task automatic cyc(input string tag, input logic [3:0] exp_state, input logic [14:0] exp_ctrl);
      #1;
      check_eq({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
      check_eq({tag, ".ctrl"},  {17'd0, w_obs}, {17'd0, exp_ctrl});
      @(negedge clk);
   endtask

   initial begin
      rst_n  = 1'b0;
      opcode = 6'h23;
      funct  = 6'h00;
      zero   = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset.state", {28'd0, state}, 32'd0);
      check_eq("reset.ctrl",  {17'd0, w_obs}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // lw, with opcode scrambled in states where it must be ignored
      cyc("lw.fetch",  4'd0, C_FETCH);
      cyc("lw.decode", 4'd1, C_DECODE);
      cyc("lw.memadr", 4'd2, C_ADR);
      opcode = 6'h2B;
      cyc("lw.memrd",  4'd3, C_MEMRD);
      opcode = 6'h04;
      cyc("lw.memwb",  4'd4, C_MEMWB);

      opcode = 6'h2B;
      cyc("sw.fetch",  4'd0, C_FETCH);
      cyc("sw.decode", 4'd1, C_DECODE);
      cyc("sw.memadr", 4'd2, C_ADR);
      cyc("sw.memwr",  4'd5, C_MEMWR);

      opcode = 6'h00; funct = 6'h2A;
      cyc("slt.fetch",  4'd0, C_FETCH);
      cyc("slt.decode", 4'd1, C_DECODE);
      cyc("slt.exec",   4'd6, C_EXEC | 15'd6);
      cyc("slt.aluwb",  4'd7, C_ALUWB);

      opcode = 6'h08;
      cyc("addi.fetch",  4'd0, C_FETCH);
      cyc("addi.decode", 4'd1, C_DECODE);
      cyc("addi.exec",   4'd9, C_ADR);
      cyc("addi.wb",     4'd10, C_ADDIWB);

      opcode = 6'h04; zero = 1'b1;
      cyc("beq1.fetch",  4'd0, C_FETCH);
      cyc("beq1.decode", 4'd1, C_DECODE);
      cyc("beq1.branch", 4'd8, C_BR_Z1);
      zero = 1'b0;
      cyc("beq0.fetch",  4'd0, C_FETCH);
      cyc("beq0.decode", 4'd1, C_DECODE);
      cyc("beq0.branch", 4'd8, C_BR_Z0);

      opcode = 6'h02;
      cyc("j.fetch",  4'd0, C_FETCH);
      cyc("j.decode", 4'd1, C_DECODE);
      cyc("j.jump",   4'd11, C_JUMP);

      opcode = 6'h3F;
      cyc("nop.fetch",  4'd0, C_FETCH);
      cyc("nop.decode", 4'd1, C_DECODE);

      opcode = 6'h00; funct = 6'h18;
      cyc("mul.fetch",  4'd0, C_FETCH);
      cyc("mul.decode", 4'd1, C_DECODE);
      cyc("mul.exec",   4'd6, C_EXEC | 15'd5);
      cyc("mul.aluwb",  4'd7, C_ALUWB);

      funct = 6'h3F;
      cyc("dflt.fetch",  4'd0, C_FETCH);
      cyc("dflt.decode", 4'd1, C_DECODE);
      cyc("dflt.exec",   4'd6, C_EXEC | 15'd2);
      cyc("dflt.aluwb",  4'd7, C_ALUWB);

      // reset in MEMWR
      opcode = 6'h2B;
      cyc("rstwr.fetch",  4'd0, C_FETCH);
      cyc("rstwr.decode", 4'd1, C_DECODE);
      cyc("rstwr.memadr", 4'd2, C_ADR);
      #1;
      check_eq("rstwr.memwr.strobe", {31'd0, mem_write}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rstwr.low.mem_write", {31'd0, mem_write}, 32'd0);
      check_eq("rstwr.low.ctrl", {17'd0, w_obs}, {17'd0, C_ZERO});
      @(negedge clk);
      rst_n = 1'b1;
      cyc("rstwr.rel.fetch",  4'd0, C_FETCH);
      cyc("rstwr.rel.decode", 4'd1, C_DECODE);

      // reset in MEMADR: without it the FSM would head to MEMWR
      cyc("rstadr.memadr", 4'd2, C_ADR);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("rstadr.low.ctrl", {17'd0, w_obs}, {17'd0, C_ZERO});
      @(negedge clk);
      rst_n = 1'b1;
      cyc("rstadr.rel.fetch",  4'd0, C_FETCH);
      cyc("rstadr.rel.decode", 4'd1, C_DECODE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock, sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- opcode  in  6  instr[31:26], from instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag, same cycle as alu_sel.
- pc_en  out  1  PC load = pc_write | (branch & zero).
- ir_write  out  1  instruction register load.
- mem_write  out  1  data memory write strobe.
- reg_write  out  1  register file write strobe.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = memory data.
- reg_dst  out  1  destination: 0 = rt, 1 = rd.
- alu_src_a  out  1  operand A: 0 = PC, 1 = reg A.
- alu_src_b  out  2  operand B: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_sel  out  3  ALU operation code.
- state  out  4  current state, for debug only.

Function
REQ-002 Control SHALL be a Moore FSM; every output except pc_en SHALL be a function of state only.
REQ-003 States, 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-004 Transitions SHALL be:
- FETCH->DECODE.
- DECODE by opcode: 0x23 or 0x2B -> MEMADR; 0x00 -> EXECUTE; 0x04 -> BRANCH; 0x08 -> ADDIEXEC; 0x02 -> JUMP.
- MEMADR->MEMRD if opcode=0x23, else ->MEMWR.
- MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP ->FETCH.
REQ-005 An unknown opcode in DECODE SHALL return to FETCH with no write strobes asserted (executes as a NOP).
REQ-006 Unencoded states 12-15 SHALL transition to FETCH with all strobes deasserted.
REQ-007 alu_sel codes SHALL be: AND=0, OR=1, ADD=2, SUB=4, MUL=5, SLT=6.
REQ-008 Per-state asserted outputs SHALL be as follows; unlisted strobes are 0, unlisted selects are don't-care and driven 0:
- FETCH: ir_write, pc_write, alu_src_b=01, alu_sel=ADD, pc_src=00.
- DECODE: alu_src_b=11, alu_sel=ADD.
- MEMADR and ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_sel=ADD.
- MEMRD: i_or_d=1.
- MEMWB: reg_write, mem_to_reg=1, reg_dst=0.
- MEMWR: i_or_d=1, mem_write.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_sel from funct.
- ALUWB: reg_write, reg_dst=1.
- ADDIWB: reg_write, reg_dst=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_sel=SUB, branch, pc_src=01.
- JUMP: pc_write, pc_src=10.
REQ-009 The funct decode in EXECUTE SHALL map 0x20->ADD, 0x22->SUB, 0x24->AND, 0x25->OR, 0x2A->SLT, 0x18->MUL, and any other value ->ADD.
REQ-010 pc_en in BRANCH SHALL follow zero combinationally in the same cycle, with no registering.
REQ-011 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown 2.
REQ-012 opcode and funct SHALL be sampled only in DECODE, MEMADR and EXECUTE; changes in other states SHALL have no effect.

Reset
REQ-013 rst_n=0 at a rising clk edge SHALL load state=FETCH, including when reset arrives mid-instruction.
REQ-014 While rst_n=0, pc_en, ir_write, mem_write and reg_write SHALL be forced to 0 combinationally; all other outputs SHALL be 0.
REQ-015 In the first cycle after rst_n rises, the block SHALL present FETCH outputs.

Structure
REQ-016 Shared package mips_pkg SHALL hold the opcode constants, funct constants, ALU sel codes and the state encoding; the ALU SHALL use the same ALU sel constants.
REQ-017 The funct->alu_sel mapping SHALL be a combinational sub-module alu_decoder, instantiated once.
REQ-018 The state register SHALL be the only sequential element in the block.

Verification
REQ-019 Reset, then opcode=0x23 held -> states 0,1,2,3,4,0; MEMWB has reg_write=1, mem_to_reg=1; MEMRD has i_or_d=1.
REQ-020 opcode=0x00, funct=0x2A -> EXECUTE has alu_sel=6; ALUWB has reg_write=1, reg_dst=1; 4 cycles total.
REQ-021 opcode=0x04 with zero=1 -> BRANCH has pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0; both return to FETCH.
REQ-022 opcode=0x3F -> FETCH, DECODE, FETCH; no reg_write or mem_write pulse observed.
REQ-023 rst_n=0 asserted in MEMWR -> next state=0, mem_write=0 while reset is low, FETCH outputs in the first cycle after release.
REQ-024 opcode=0x00, funct=0x18 -> alu_sel=5 in EXECUTE; funct=0x3F -> alu_sel=2.
